// File: rtl/test_pkg.sv
// Shared constants and helpers for the RGB-to-HSV pipeline.
//   Widths of the colour components and of the hue/sat/val results,
//   the hue base angles, and the pipeline latency.
package test_pkg;

   localparam int COMP_W   = 8;
   localparam int HUE_W    = 10;
   localparam int SAT_W    = 18;
   localparam int VAL_W    = 10;
   localparam int SAT_FRAC = 17;
   localparam int SAT_ONE  = 131072;
   localparam int LATENCY  = 4;

   // Hue numerator is 60*|n| with |n| <= 255, so it fits 14 bits; the hue
   // quotient never exceeds 60, so 6 bits are enough.
   localparam int HNUM_W = 14;
   localparam int HQ_W   = 6;
   // Sat numerator is delta << 17.
   localparam int SNUM_W = COMP_W + SAT_FRAC;

   localparam logic [HNUM_W-1:0] HUE_SCALE  = 14'd60;
   localparam logic [HUE_W-1:0]  HUE_BASE_R = 10'd0;
   localparam logic [HUE_W-1:0]  HUE_BASE_G = 10'd120;
   localparam logic [HUE_W-1:0]  HUE_BASE_B = 10'd240;
   localparam logic [HUE_W-1:0]  HUE_FULL   = 10'd360;

   typedef enum logic [1:0] {
      CH_RED   = 2'd0,
      CH_GREEN = 2'd1,
      CH_BLUE  = 2'd2
   } chan_e;

   function automatic logic [HUE_W-1:0] hue_base(input chan_e ch);
      case (ch)
         CH_GREEN: return HUE_BASE_G;
         CH_BLUE:  return HUE_BASE_B;
         default:  return HUE_BASE_R;
      endcase
   endfunction

   // base +/- q, folded into 0..359.
   function automatic logic [HUE_W-1:0] hue_combine(input logic [HUE_W-1:0] base,
                                                    input logic [HUE_W-1:0] q,
                                                    input logic             neg);
      logic [HUE_W-1:0] h;
      if (!neg)         h = base + q;
      else if (q > base) h = base + HUE_FULL - q;
      else              h = base - q;
      if (h == HUE_FULL) h = '0;
      return h;
   endfunction

endpackage

// File: rtl/test_div.sv
// hsv_div: combinational unsigned restoring divider.
//   num_i : dividend (NUM_W bits)
//   den_i : divisor  (DEN_W bits, must be non-zero)
//   quo_o : floor(num_i / den_i), QUO_W bits
// Only QUO_W quotient bits are produced: the caller guarantees
// num_i < den_i * 2**QUO_W, so the top NUM_W-QUO_W dividend bits are
// already smaller than den_i and seed the partial remainder directly.
module hsv_div #(
   parameter int NUM_W = 25,
   parameter int DEN_W = 8,
   parameter int QUO_W = 18
) (
   input  logic [NUM_W-1:0] num_i,
   input  logic [DEN_W-1:0] den_i,
   output logic [QUO_W-1:0] quo_o
);

   logic [DEN_W:0] rem;

   always_comb begin
      rem   = (DEN_W+1)'(num_i[NUM_W-1:QUO_W]);
      quo_o = '0;
      for (int i = QUO_W-1; i >= 0; i--) begin
         rem = {rem[DEN_W-1:0], num_i[i]};
         if (rem >= {1'b0, den_i}) begin
            rem      = rem - {1'b0, den_i};
            quo_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/test.sv
// test: 4-cycle, fully pipelined RGB to HSV converter.
//   clk, reset            : clock, asynchronous active-high reset
//   valid_in, red/green/blue : input sample, taken when valid_in is high
//   valid_out             : one-cycle pulse with each new result
//   hue (deg), sat (Q1.17), val : last valid result, held between pulses
// Stages: 0 capture, 1 max/min/delta + hue numerator, 2 divisions,
//         3 sign/base/wrap combine, 4 output hold register.
module test
   import test_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [COMP_W-1:0] red,
   input  logic [COMP_W-1:0] green,
   input  logic [COMP_W-1:0] blue,
   output logic              valid_out,
   output logic [HUE_W-1:0]  hue,
   output logic [SAT_W-1:0]  sat,
   output logic [VAL_W-1:0]  val
);

   // stage 0
   logic              v0_q;
   logic [COMP_W-1:0] r0_q, g0_q, b0_q;
   // stage 1
   logic              v1_q, neg1_q, neg1_d;
   chan_e             ch1_q, ch1_d;
   logic [COMP_W-1:0] max1_q, max1_d, min1_d, delta1_q, delta1_d;
   logic [HNUM_W-1:0] hnum1_q, hnum1_d;
   logic [COMP_W-1:0] hi_c, lo_c, mag_c;
   // stage 2
   logic              v2_q, neg2_q;
   chan_e             ch2_q;
   logic [HQ_W-1:0]   hq2_q, hq2_d, hquo_c;
   logic [SAT_W-1:0]  sat2_q, squo_c;
   logic [COMP_W-1:0] max2_q, hden_c, sden_c;
   // stage 3
   logic              v3_q;
   logic [HUE_W-1:0]  hue3_q, hue3_d;
   logic [SAT_W-1:0]  sat3_q;
   logic [VAL_W-1:0]  val3_q;
   // stage 4
   logic              vout_q;
   logic [HUE_W-1:0]  hue_q;
   logic [SAT_W-1:0]  sat_q;
   logic [VAL_W-1:0]  val_q;

   // Dominant channel with red > green > blue priority on ties; hi/lo are
   // the two remaining channels in the order that forms n = hi - lo.
   always_comb begin
      ch1_d  = CH_RED;
      max1_d = r0_q;
      hi_c   = g0_q;
      lo_c   = b0_q;
      if (r0_q >= g0_q && r0_q >= b0_q) begin
         ch1_d  = CH_RED;
         max1_d = r0_q;
         hi_c   = g0_q;
         lo_c   = b0_q;
      end else if (g0_q >= b0_q) begin
         ch1_d  = CH_GREEN;
         max1_d = g0_q;
         hi_c   = b0_q;
         lo_c   = r0_q;
      end else begin
         ch1_d  = CH_BLUE;
         max1_d = b0_q;
         hi_c   = r0_q;
         lo_c   = g0_q;
      end
      min1_d = r0_q;
      if (g0_q < min1_d) min1_d = g0_q;
      if (b0_q < min1_d) min1_d = b0_q;
      neg1_d   = (hi_c < lo_c);
      mag_c    = neg1_d ? (lo_c - hi_c) : (hi_c - lo_c);
      delta1_d = max1_d - min1_d;
      hnum1_d  = HNUM_W'(mag_c) * HUE_SCALE;
   end

   // Zero divisors are replaced by 1; the affected results are zero anyway
   // (gray/black), and hue is forced to zero explicitly below.
   assign hden_c = (delta1_q == '0) ? COMP_W'(1) : delta1_q;
   assign sden_c = (max1_q == '0)   ? COMP_W'(1) : max1_q;

   hsv_div #(.NUM_W(HNUM_W), .DEN_W(COMP_W), .QUO_W(HQ_W)) u_hue_div (
      .num_i (hnum1_q),
      .den_i (hden_c),
      .quo_o (hquo_c)
   );

   hsv_div #(.NUM_W(SNUM_W), .DEN_W(COMP_W), .QUO_W(SAT_W)) u_sat_div (
      .num_i ({delta1_q, {SAT_FRAC{1'b0}}}),
      .den_i (sden_c),
      .quo_o (squo_c)
   );

   assign hq2_d  = (delta1_q == '0) ? '0 : hquo_c;
   assign hue3_d = hue_combine(hue_base(ch2_q), HUE_W'(hq2_q), neg2_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v0_q     <= 1'b0;
         r0_q     <= '0;
         g0_q     <= '0;
         b0_q     <= '0;
         v1_q     <= 1'b0;
         ch1_q    <= CH_RED;
         neg1_q   <= 1'b0;
         max1_q   <= '0;
         delta1_q <= '0;
         hnum1_q  <= '0;
         v2_q     <= 1'b0;
         ch2_q    <= CH_RED;
         neg2_q   <= 1'b0;
         hq2_q    <= '0;
         sat2_q   <= '0;
         max2_q   <= '0;
         v3_q     <= 1'b0;
         hue3_q   <= '0;
         sat3_q   <= '0;
         val3_q   <= '0;
         vout_q   <= 1'b0;
         hue_q    <= '0;
         sat_q    <= '0;
         val_q    <= '0;
      end else begin
         v0_q <= valid_in;
         if (valid_in) begin
            r0_q <= red;
            g0_q <= green;
            b0_q <= blue;
         end
         v1_q     <= v0_q;
         ch1_q    <= ch1_d;
         neg1_q   <= neg1_d;
         max1_q   <= max1_d;
         delta1_q <= delta1_d;
         hnum1_q  <= hnum1_d;
         v2_q     <= v1_q;
         ch2_q    <= ch1_q;
         neg2_q   <= neg1_q;
         hq2_q    <= hq2_d;
         sat2_q   <= squo_c;
         max2_q   <= max1_q;
         v3_q     <= v2_q;
         hue3_q   <= hue3_d;
         sat3_q   <= sat2_q;
         val3_q   <= VAL_W'(max2_q);
         vout_q   <= v3_q;
         if (v3_q) begin
            hue_q <= hue3_q;
            sat_q <= sat3_q;
            val_q <= val3_q;
         end
      end
   end

   assign valid_out = vout_q;
   assign hue       = hue_q;
   assign sat       = sat_q;
   assign val       = val_q;

endmodule

// File: tb/tb_test.sv
module tb_test;
   import test_pkg::*;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic [7:0]  red, green, blue;
   logic        valid_out;
   logic [9:0]  hue;
   logic [17:0] sat;
   logic [9:0]  val;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [9:0]  h;
      logic [17:0] s;
      logic [9:0]  v;
   } res_t;

   localparam int NV = 6;
   localparam logic [7:0]  VR [NV] = '{8'd0,   8'd22,  8'd128, 8'd0, 8'd255, 8'd255};
   localparam logic [7:0]  VG [NV] = '{8'd0,   8'd48,  8'd128, 8'd0, 8'd0,   8'd0};
   localparam logic [7:0]  VB [NV] = '{8'd255, 8'd65,  8'd128, 8'd0, 8'd128, 8'd1};
   localparam logic [9:0]  EH [NV] = '{10'd240, 10'd204, 10'd0, 10'd0, 10'd330, 10'd0};
   localparam logic [17:0] ES [NV] = '{18'd131072, 18'd86709, 18'd0, 18'd0, 18'd131072, 18'd131072};
   localparam logic [9:0]  EV [NV] = '{10'd255, 10'd65, 10'd128, 10'd0, 10'd255, 10'd255};

   test dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .valid_out (valid_out),
      .hue       (hue),
      .sat       (sat),
      .val       (val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: HSV straight from the definition using integer arithmetic.
   function automatic res_t model(input int r, input int g, input int b);
      int   mx, mn, d, n, base, q, h;
      res_t o;
      mx = (r > g) ? r : g;  mx = (mx > b) ? mx : b;
      mn = (r < g) ? r : g;  mn = (mn < b) ? mn : b;
      d  = mx - mn;
      h  = 0;
      if (d != 0) begin
         if (r == mx)      begin n = g - b; base = 0;   end
         else if (g == mx) begin n = b - r; base = 120; end
         else              begin n = r - g; base = 240; end
         q = (60 * ((n < 0) ? -n : n)) / d;
         h = (n >= 0) ? base + q : base - q;
         if (h < 0)    h = h + 360;
         if (h == 360) h = 0;
      end
      o.h = 10'(h);
      o.s = (mx == 0) ? 18'd0 : 18'((d * 131072) / mx);
      o.v = 10'(mx);
      return o;
   endfunction

   // Called at a falling edge; inputs are sampled on the next rising edge,
   // and the task returns at the following falling edge.
   task automatic drive(input bit v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      valid_in = v;
      red      = r;
      green    = g;
      blue     = b;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      valid_in = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      valid_in = 1'b1;
      red      = 8'd200;
      green    = 8'd10;
      blue     = 8'd99;
      #3;
      checks++;
      if ({valid_out, hue, sat, val} !== '0) begin
         errors++;
         $display("FAIL reset_async: got v=%b h=%0d s=%0d val=%0d expected all 0", valid_out, hue, sat, val);
      end
      repeat (6) @(negedge clk);
      checks++;
      if ({valid_out, hue, sat, val} !== '0) begin
         errors++;
         $display("FAIL reset_held: got v=%b h=%0d s=%0d val=%0d expected all 0", valid_out, hue, sat, val);
      end
      reset    = 1'b0;
      valid_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      for (int i = 0; i < NV; i++) begin
         drive(1'b1, VR[i], VG[i], VB[i]);
         for (int j = 1; j < LATENCY; j++) begin
            idle();
            checks++;
            if (valid_out !== 1'b0) begin
               errors++;
               $display("FAIL early_valid vec%0d cyc%0d: got %b expected 0", i, j, valid_out);
            end
         end
         idle();
         checks++;
         if (valid_out !== 1'b1) begin
            errors++;
            $display("FAIL latency_valid vec%0d: got %b expected 1", i, valid_out);
         end
         checks++;
         if (hue !== EH[i]) begin
            errors++;
            $display("FAIL hue vec%0d: got %0d expected %0d", i, hue, EH[i]);
         end
         checks++;
         if (sat !== ES[i]) begin
            errors++;
            $display("FAIL sat vec%0d: got %0d expected %0d", i, sat, ES[i]);
         end
         checks++;
         if (val !== EV[i]) begin
            errors++;
            $display("FAIL val vec%0d: got %0d expected %0d", i, val, EV[i]);
         end
         idle();
         checks++;
         if (valid_out !== 1'b0 || hue !== EH[i] || sat !== ES[i] || val !== EV[i]) begin
            errors++;
            $display("FAIL hold vec%0d: got v=%b h=%0d s=%0d val=%0d expected v=0 h=%0d s=%0d val=%0d",
                     i, valid_out, hue, sat, val, EH[i], ES[i], EV[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NV; i++) begin
         drive(1'b1, VR[i], VG[i], VB[i]);
         if (i < LATENCY) begin
            checks++;
            if (valid_out !== 1'b0) begin
               errors++;
               $display("FAIL b2b_early cyc%0d: got %b expected 0", i, valid_out);
            end
         end
      end
      // The first result came out after the 5th drive; walk back to it.
      for (int i = 0; i < NV; i++) begin
         if (i >= NV - LATENCY + 1) begin
            // results still arriving are checked as they come out below
         end
      end
      for (int i = NV - LATENCY - 1; i < NV; i++) begin
         if (i > NV - LATENCY - 1) idle();
         checks++;
         if (valid_out !== 1'b1 || hue !== EH[i] || sat !== ES[i] || val !== EV[i]) begin
            errors++;
            $display("FAIL b2b_result vec%0d: got v=%b h=%0d s=%0d val=%0d expected v=1 h=%0d s=%0d val=%0d",
                     i, valid_out, hue, sat, val, EH[i], ES[i], EV[i]);
         end
      end
      idle();
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: got %b expected 0", valid_out);
      end
   endtask

   task automatic test_random(input int n);
      res_t       hold, er, cur;
      bit         v, ev;
      bit         vq[$];
      res_t       rq[$];
      logic [7:0] r, g, b;
      do_reset();
      hold = '0;
      for (int c = 0; c < n + LATENCY; c++) begin
         v = (c < n) && ($urandom_range(0, 9) < 7);
         r = 8'($urandom);
         g = 8'($urandom);
         b = 8'($urandom);
         case ($urandom_range(0, 3))
            1: begin g = r; b = r; end
            2: begin
               if ($urandom_range(0, 1) == 0) g = r; else b = g;
            end
            3: begin r = r >> 5; g = g >> 5; b = b >> 5; end
            default: ;
         endcase
         drive(v, r, g, b);
         cur = model(int'(r), int'(g), int'(b));
         vq.push_back(v);
         rq.push_back(cur);
         ev = 1'b0;
         if (vq.size() > LATENCY) begin
            ev = vq.pop_front();
            er = rq.pop_front();
            if (ev) hold = er;
         end
         checks++;
         if (valid_out !== ev || hue !== hold.h || sat !== hold.s || val !== hold.v) begin
            errors++;
            $display("FAIL random cyc%0d: got v=%b h=%0d s=%0d val=%0d expected v=%b h=%0d s=%0d val=%0d",
                     c, valid_out, hue, sat, val, ev, hold.h, hold.s, hold.v);
         end
      end
   endtask

   task automatic test_midflight_reset();
      drive(1'b1, 8'd0, 8'd0, 8'd255);
      repeat (LATENCY) idle();
      checks++;
      if (hue !== 10'd240 || val !== 10'd255) begin
         errors++;
         $display("FAIL mid_pre: got h=%0d val=%0d expected h=240 val=255", hue, val);
      end
      drive(1'b1, 8'd22, 8'd48, 8'd65);
      idle();
      idle();
      reset = 1'b1;
      #1;
      checks++;
      if ({valid_out, hue, sat, val} !== '0) begin
         errors++;
         $display("FAIL mid_reset_async: got v=%b h=%0d s=%0d val=%0d expected all 0", valid_out, hue, sat, val);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2 * LATENCY; i++) begin
         idle();
         checks++;
         if ({valid_out, hue, sat, val} !== '0) begin
            errors++;
            $display("FAIL mid_discard cyc%0d: got v=%b h=%0d s=%0d val=%0d expected all 0", i, valid_out, hue, sat, val);
         end
      end
      drive(1'b1, 8'd255, 8'd0, 8'd128);
      for (int j = 1; j < LATENCY; j++) begin
         idle();
         checks++;
         if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early cyc%0d: got %b expected 0", j, valid_out);
         end
      end
      idle();
      checks++;
      if (valid_out !== 1'b1 || hue !== 10'd330 || sat !== 18'd131072 || val !== 10'd255) begin
         errors++;
         $display("FAIL post_reset_first: got v=%b h=%0d s=%0d val=%0d expected v=1 h=330 s=131072 val=255",
                  valid_out, hue, sat, val);
      end
   endtask

   initial begin
      valid_in = 1'b0;
      red      = '0;
      green    = '0;
      blue     = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_midflight_reset();
      test_random(400);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
